fnd_scan_ctrl: RTL and testbench

- Multiplexed N-digit 7-segment (FND) display controller that scans one digit per time slot.
- Decodes a latched hex word into active-low segment patterns, ordered {a,b,c,d,e,f,g} with a as the MSB.
- Adds per-digit decimal points, leading-zero blanking, anti-ghosting dead time and common-pin polarity selection.
- Sits between register/SPI-fed display data and the board's FND pins.

---
 rtl/fnd_pkg.sv | 17 +
 rtl/fnd_hex_dec.sv | 11 +
 rtl/fnd_scan_ctrl.sv | 96 +++++++++
 tb/tb_fnd_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and helpers for the multiplexed 7-segment scanner.
package fnd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g}, a in the MSB, indexed by hex value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0D,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    // Turns a one-hot "digit enabled" mask into pin levels for the board's common polarity.
    function automatic logic [7:0] com_level(input logic [7:0] mask, input bit active_low);
        return active_low ? ~mask : mask;
    endfunction

endpackage

// File: rtl/fnd_hex_dec.sv
// fnd_hex_dec: combinational hex nibble to active-low 7-segment pattern.
module fnd_hex_dec
    import fnd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed N-digit FND driver with dead time, decimal points
// and leading-zero blanking; all pin outputs are registered.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD_CYC       = 16,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            fnd_seg,
    output logic                  fnd_dp,
    output logic [N_DIGITS-1:0]   fnd_com,
    output logic [2:0]            scan_idx
);

    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] COM_OFF = N_DIGITS'(com_level(8'h00, COM_ACTIVE_LOW));

    logic [4*N_DIGITS-1:0] sh_val;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [3:0]            nib;
    logic [6:0]            dec_seg;
    logic [N_DIGITS-1:0]   lz;
    logic [N_DIGITS-1:0]   sel;
    logic [N_DIGITS-1:0]   com_on;
    logic                  on;
    logic                  blank;
    logic                  run;

    assign nib      = sh_val[4*idx +: 4];
    assign sel      = N_DIGITS'(1) << idx;
    assign com_on   = N_DIGITS'(com_level(8'(sel), COM_ACTIVE_LOW));
    assign scan_idx = 3'(idx);

    fnd_hex_dec u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    // lz[k] is set when digit k and every more-significant digit are zero.
    always_comb begin
        run = 1'b1;
        lz  = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            run   = run & (sh_val[4*k +: 4] == 4'h0);
            lz[k] = run;
        end
        on    = cnt >= CNT_ON;
        blank = blank_lz && idx != '0 && lz[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val  <= '0;
            sh_dp   <= '0;
            cnt     <= '0;
            idx     <= '0;
            fnd_seg <= SEG_BLANK;
            fnd_dp  <= 1'b1;
            fnd_com <= COM_OFF;
        end else begin
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp_in;
            end
            if (!en) begin
                cnt     <= '0;
                idx     <= '0;
                fnd_seg <= SEG_BLANK;
                fnd_dp  <= 1'b1;
                fnd_com <= COM_OFF;
            end else begin
                cnt     <= cnt == CNT_LAST ? '0 : cnt + 1'b1;
                idx     <= cnt != CNT_LAST ? idx : (idx == IDX_LAST ? '0 : idx + 1'b1);
                fnd_seg <= on && !blank ? dec_seg : SEG_BLANK;
                fnd_dp  <= on ? ~sh_dp[idx] : 1'b1;
                fnd_com <= on ? com_on : COM_OFF;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: randomized and directed checks of fnd_scan_ctrl against a
// slot-arithmetic reference model (N=4, SCAN_DIV=8, DEAD_CYC=2, active-low commons).
module tb_fnd_scan_ctrl;

    localparam int N = 4;
    localparam int DIV = 8;
    localparam int DEAD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  fnd_seg;
    logic        fnd_dp;
    logic [3:0]  fnd_com;
    logic [2:0]  scan_idx;

    int errors = 0;
    int checks = 0;

    int          t;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_com;
    logic [2:0]  e_idx;

    logic [6:0] tbl [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0D,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    fnd_scan_ctrl #(
        .N_DIGITS       (N),
        .SCAN_DIV       (DIV),
        .DEAD_CYC       (DEAD),
        .COM_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .fnd_seg  (fnd_seg),
        .fnd_dp   (fnd_dp),
        .fnd_com  (fnd_com),
        .scan_idx (scan_idx)
    );

    always #5 clk = ~clk;

    // One clock of the model: t counts enabled cycles since scanning (re)started,
    // so the slot is t/DIV mod N and the position within the slot is t mod DIV.
    task automatic step();
        int d;
        int p;
        logic [3:0] nib;
        @(posedge clk);
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_com = 4'hF;
        if (!en) begin
            t = 0;
        end else begin
            d = (t / DIV) % N;
            p = t % DIV;
            if (p >= DEAD) begin
                nib   = 4'(m_val >> (4 * d));
                e_com = ~(4'b0001 << d);
                e_seg = (blank_lz && d > 0 && (m_val >> (4 * d)) == 0) ? 7'h7F : tbl[nib];
                e_dp  = ~m_dp[d];
            end
            t++;
        end
        e_idx = 3'((t / DIV) % N);
        if (load) begin
            m_val = value;
            m_dp  = dp_in;
        end
        #1;
    endtask

    task automatic model_reset();
        t = 0;
        m_val = '0;
        m_dp = '0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        value = 16'hBEEF;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (13) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({fnd_seg, fnd_dp, fnd_com, scan_idx} !== {7'h7F, 1'b1, 4'hF, 3'd0}) begin
            errors++;
            $display("FAIL reset_async: seg=%h dp=%b com=%b idx=%0d, want seg=7f dp=1 com=1111 idx=0",
                     fnd_seg, fnd_dp, fnd_com, scan_idx);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({fnd_seg, fnd_dp, fnd_com, scan_idx} !== {7'h7F, 1'b1, 4'hF, 3'd0}) begin
                errors++;
                $display("FAIL reset_hold: seg=%h dp=%b com=%b idx=%0d, want seg=7f dp=1 com=1111 idx=0",
                         fnd_seg, fnd_dp, fnd_com, scan_idx);
            end
        end
        model_reset();
        en = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_scan();
        value = 16'h1234;
        dp_in = 4'b0000;
        blank_lz = 1'b0;
        load = 1'b1;
        step();
        load = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4 * N * DIV / 2; i++) begin
            step();
            checks++;
            if ({fnd_seg, fnd_dp, fnd_com, scan_idx} !== {e_seg, e_dp, e_com, e_idx}) begin
                errors++;
                $display("FAIL full_scan[%0d]: seg=%h dp=%b com=%b idx=%0d, want seg=%h dp=%b com=%b idx=%0d",
                         i, fnd_seg, fnd_dp, fnd_com, scan_idx, e_seg, e_dp, e_com, e_idx);
            end
        end
    endtask

    task automatic test_dp_wrap();
        dp_in = 4'b0100;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 2 * N * DIV; i++) begin
            step();
            checks++;
            if ({fnd_seg, fnd_dp, fnd_com, scan_idx} !== {e_seg, e_dp, e_com, e_idx}) begin
                errors++;
                $display("FAIL dp_wrap[%0d]: seg=%h dp=%b com=%b idx=%0d, want seg=%h dp=%b com=%b idx=%0d",
                         i, fnd_seg, fnd_dp, fnd_com, scan_idx, e_seg, e_dp, e_com, e_idx);
            end
        end
    endtask

    task automatic test_blanking();
        value = 16'h0070;
        dp_in = 4'b1000;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int b = 1; b >= 0; b--) begin
            blank_lz = b[0];
            for (int i = 0; i < N * DIV; i++) begin
                step();
                checks++;
                if ({fnd_seg, fnd_dp, fnd_com, scan_idx} !== {e_seg, e_dp, e_com, e_idx}) begin
                    errors++;
                    $display("FAIL blank_lz%0d[%0d]: seg=%h dp=%b com=%b idx=%0d, want seg=%h dp=%b com=%b idx=%0d",
                             b, i, fnd_seg, fnd_dp, fnd_com, scan_idx, e_seg, e_dp, e_com, e_idx);
                end
            end
        end
    endtask

    task automatic test_decode();
        blank_lz = 1'b1;
        dp_in = 4'b0000;
        for (int h = 0; h < 16; h++) begin
            en = 1'b0;
            step();
            en = 1'b1;
            value = 16'(h);
            load = 1'b1;
            step();
            load = 1'b0;
            for (int i = 0; i < DIV; i++) begin
                step();
                checks++;
                if ({fnd_seg, fnd_dp, fnd_com, scan_idx} !== {e_seg, e_dp, e_com, e_idx}) begin
                    errors++;
                    $display("FAIL decode_%h[%0d]: seg=%h com=%b idx=%0d, want seg=%h com=%b idx=%0d",
                             h[3:0], i, fnd_seg, fnd_com, scan_idx, e_seg, e_com, e_idx);
                end
            end
        end
    endtask

    task automatic test_enable_load();
        value = 16'h5A5A;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (DIV + 4) step();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({fnd_seg, fnd_dp, fnd_com, scan_idx} !== {7'h7F, 1'b1, 4'hF, 3'd0}) begin
                errors++;
                $display("FAIL en_off[%0d]: seg=%h dp=%b com=%b idx=%0d, want seg=7f dp=1 com=1111 idx=0",
                         i, fnd_seg, fnd_dp, fnd_com, scan_idx);
            end
        end
        en = 1'b1;
        value = 16'hC0DE;
        dp_in = 4'b0001;
        load = 1'b1;
        for (int i = 0; i < N * DIV; i++) begin
            step();
            load = 1'b0;
            checks++;
            if ({fnd_seg, fnd_dp, fnd_com, scan_idx} !== {e_seg, e_dp, e_com, e_idx}) begin
                errors++;
                $display("FAIL en_load[%0d]: seg=%h dp=%b com=%b idx=%0d, want seg=%h dp=%b com=%b idx=%0d",
                         i, fnd_seg, fnd_dp, fnd_com, scan_idx, e_seg, e_dp, e_com, e_idx);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] masks [4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
        for (int i = 0; i < 600; i++) begin
            en = $urandom_range(0, 24) != 0;
            load = $urandom_range(0, 6) == 0;
            value = 16'($urandom) & masks[$urandom_range(0, 3)];
            dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            step();
            checks++;
            if ({fnd_seg, fnd_dp, fnd_com, scan_idx} !== {e_seg, e_dp, e_com, e_idx}) begin
                errors++;
                $display("FAIL random[%0d]: seg=%h dp=%b com=%b idx=%0d, want seg=%h dp=%b com=%b idx=%0d",
                         i, fnd_seg, fnd_dp, fnd_com, scan_idx, e_seg, e_dp, e_com, e_idx);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        model_reset();
        #23 rst_n = 1'b1;
        step();
        test_reset();
        test_full_scan();
        test_dp_wrap();
        test_blanking();
        test_decode();
        test_enable_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
